// File: rtl/regs_wb_arbiter.sv
// Write-port arbiter for the 32x32 integer register file. It merges pipeline writeback with
// long-latency results and keeps a busy scoreboard that drives the issue hazard.
module regs_wb_arbiter #(
   parameter int STARVE_LIMIT    = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ex_wen_i,
   input  logic [4:0]  ex_addr_i,
   input  logic [31:0] ex_data_i,
   input  logic        lu_valid_i,
   input  logic [4:0]  lu_addr_i,
   input  logic [31:0] lu_data_i,
   output logic        lu_ready_o,
   input  logic        iss_valid_i,
   input  logic        iss_long_i,
   input  logic [4:0]  iss_rs1_i,
   input  logic [4:0]  iss_rs2_i,
   input  logic [4:0]  iss_rd_i,
   output logic        hazard_o,
   output logic        stall_o,
   output logic        RegWEn_o,
   output logic [4:0]  AddrD_o,
   output logic [31:0] DataD_o
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic [SW-1:0] starveCnt_q, starveCnt_d;
   logic [CW-1:0] outCnt_q, outCnt_d;
   logic [31:0]   busy_q, busy_d;

   logic          starved;
   logic          luGrant;
   logic          exGrant;
   logic          clrEn;
   logic          setEn;
   logic          capFull;
   logic [31:0]   effBusy;

   // Outputs are gated by reset so nothing leaks onto the write port while it is held.
   always_comb begin
      starved    = lu_valid_i && (starveCnt_q == SW'(STARVE_LIMIT));
      luGrant    = !rst_i && lu_valid_i && (starved || !ex_wen_i);
      exGrant    = !rst_i && ex_wen_i && !starved;
      stall_o    = !rst_i && starved;
      lu_ready_o = luGrant;
      RegWEn_o   = 1'b0;
      AddrD_o    = 5'd0;
      DataD_o    = 32'd0;
      if (exGrant) begin
         RegWEn_o = (ex_addr_i != 5'd0);
         AddrD_o  = ex_addr_i;
         DataD_o  = ex_data_i;
      end else if (luGrant) begin
         RegWEn_o = (lu_addr_i != 5'd0);
         AddrD_o  = lu_addr_i;
         DataD_o  = lu_data_i;
      end
   end

   // A register retiring this cycle is visible through write-through, so it is not a hazard.
   // Capacity only frees up when the retire actually clears a tracked destination.
   always_comb begin
      clrEn   = luGrant && busy_q[lu_addr_i];
      effBusy = busy_q & ~({31'd0, luGrant} << lu_addr_i);
      capFull = iss_long_i && (outCnt_q == CW'(MAX_OUTSTANDING)) && !clrEn;
      hazard_o = !rst_i && iss_valid_i &&
                 (effBusy[iss_rs1_i] || effBusy[iss_rs2_i] || effBusy[iss_rd_i] || capFull);
      setEn   = iss_valid_i && iss_long_i && !hazard_o && (iss_rd_i != 5'd0);
   end

   always_comb begin
      busy_d = busy_q;
      if (clrEn) begin
         busy_d[lu_addr_i] = 1'b0;
      end
      if (setEn) begin
         busy_d[iss_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;

      outCnt_d = outCnt_q;
      if (setEn && !clrEn) begin
         outCnt_d = outCnt_q + CW'(1);
      end else if (clrEn && !setEn) begin
         outCnt_d = outCnt_q - CW'(1);
      end

      starveCnt_d = starveCnt_q;
      if (!lu_valid_i || luGrant) begin
         starveCnt_d = '0;
      end else if (starveCnt_q != SW'(STARVE_LIMIT)) begin
         starveCnt_d = starveCnt_q + SW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q      <= '0;
         outCnt_q    <= '0;
         starveCnt_q <= '0;
      end else begin
         busy_q      <= busy_d;
         outCnt_q    <= outCnt_d;
         starveCnt_q <= starveCnt_d;
      end
   end

   // Issue already blocks any pipeline write to an outstanding long destination.
   assert property (@(posedge clk_i) disable iff (rst_i) !(ex_wen_i && busy_q[ex_addr_i]));

endmodule
